openfire_mem_arbiter: RTL
=========================

Name: openfire_mem_arbiter

Overview:
Shares one external single-port memory bus between the openfire CPU instruction port (imem_*) and data port (dmem_*). It arbitrates level-held requests and runs a req/ack transaction on the bus. It steers byte and half-word lanes big-endian, flags misaligned data accesses, and aborts transactions that exceed a timeout. It sits between the CPU top level and the board memory/peripheral decoder.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for mem_ack before aborting; 0 disables the timeout.
FAIR_LIMIT, 4, consecutive data grants allowed while imem is waiting before imem is forced.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_addr  in  32  instruction address
imem_re  in  1  instruction read request, held until imem_done
imem_data  out  32  instruction word, valid with imem_done
imem_done  out  1  one-cycle completion pulse
dmem_addr  in  32  data byte address
dmem_data_w  in  32  store data, right-justified
dmem_we  in  1  store request, held until dmem_done
dmem_re  in  1  load request, held until dmem_done
dmem_input_sel  in  2  access size: 0=byte, 1=half-word, 2=word, 3=reserved (treated as word)
dmem_data_r  out  32  load data, right-justified and zero-extended, valid with dmem_done
dmem_done  out  1  one-cycle completion pulse
dmem_alignment_exception  out  1  one-cycle pulse instead of dmem_done on misaligned access
bus_error  out  1  one-cycle pulse alongside the done of a timed-out transaction
mem_addr  out  32  bus word address, bits[1:0] forced 00
mem_wdata  out  32  lane-replicated write data
mem_be  out  4  byte enables; be[3] = bits 31:24 = byte offset 0
mem_we  out  1  bus write strobe
mem_req  out  1  bus request, held until mem_ack
mem_ack  in  1  bus completion, samples mem_rdata
mem_rdata  in  32  bus read data

Behaviour:
- Reset values: all outputs 0; state IDLE; fairness counter 0; timeout counter 0.
- States:
  - IDLE, IBUS, DBUS, DONE.
  - The DONE cycle drives exactly one done pulse. The next cycle is IDLE, where the CPU has deasserted or changed its request.
- Arbitration in IDLE:
  - dmem (re or we) has priority.
  - If imem_re is also pending and the fairness counter equals FAIR_LIMIT, grant imem and clear the counter.
  - The counter increments on each dmem grant made while imem_re is high. It clears on any imem grant.
  - dmem_we and dmem_re both high is treated as a store.
- Alignment: a dmem request with half-word and addr[0]=1, or word and addr[1:0]!=0, never reaches the bus.
  - IDLE goes to DONE; dmem_alignment_exception pulses; dmem_done stays 0.
- Grant: the bus outputs are registered on entry to IBUS/DBUS and mem_req rises the same cycle. Bus outputs stay stable until mem_ack.
- mem_be:
  - byte: one-hot per offset 0..3 → 1000, 0100, 0010, 0001.
  - half-word: offset 0 → 1100, offset 2 → 0011.
  - word: 1111.
  - Loads also drive these enables.
- mem_wdata:
  - byte: data[7:0] replicated ×4.
  - half-word: data[15:0] replicated ×2.
  - word: as is.
- On mem_ack:
  - Capture and steer the read data.
  - Deassert mem_req the next cycle, entering DONE.
  - Minimum latency from request to done is 3 cycles with mem_ack in the first bus cycle.
- mem_ack while in IDLE or DONE is ignored.
- Timeout:
  - The counter runs while in IBUS/DBUS.
  - On reaching TIMEOUT_CYCLES: drop mem_req, go to DONE, pulse done plus bus_error, return data 0.
- Request withdrawn mid-transaction (CPU flush): the bus transaction still completes. The done pulse is still issued.
- Asynchronous reset mid-transaction: mem_req drops immediately. No done is issued.

Decomposition:
- Package openfire_mem_pkg: state encodings, access-size codes, byte-enable constants.
- Sub-module openfire_lane_steer (combinational): size + offset → mem_be, replicated write data, read-data extraction. The arbiter FSM instantiates it once.

Test Plan:
- Word load: dmem_re, addr 0x100, mem_rdata 0xDEADBEEF, ack in bus cycle 1 → mem_be 1111, dmem_data_r 0xDEADBEEF, dmem_done at cycle 3.
- Byte load: offset 2, size 0, mem_rdata 0x11223344 → mem_be 0010, dmem_data_r 0x00000033.
- Half-word store: addr 0x202, data 0xABCD1234 → mem_addr 0x200, mem_be 0011, mem_wdata 0x12341234, mem_we 1.
- Misaligned word load: addr 0x103 → no mem_req, dmem_alignment_exception pulses 1 cycle, dmem_done 0.
- Fairness: imem_re held with 6 back-to-back dmem requests, FAIR_LIMIT=4 → order D,D,D,D,I,D,D.
- Timeout: TIMEOUT_CYCLES=8, mem_ack never asserted → mem_req drops after 8 bus cycles, imem_done and bus_error pulse together, imem_data 0.

Source files
------------

// File: rtl/openfire_mem_pkg.sv
// Shared constants for the openfire memory arbiter: FSM state codes,
// data access-size codes and big-endian byte-enable patterns.
package openfire_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IBUS = 2'd1;
  localparam logic [1:0] ST_DBUS = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // be[3] covers bits 31:24, which is byte offset 0 (big-endian)
  localparam logic [3:0] BE_B0   = 4'b1000;
  localparam logic [3:0] BE_B1   = 4'b0100;
  localparam logic [3:0] BE_B2   = 4'b0010;
  localparam logic [3:0] BE_B3   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b1100;
  localparam logic [3:0] BE_H2   = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Misalignment: half-words need an even address, words (and the
  // reserved size, which behaves as a word) need a word address.
  function automatic logic f_misaligned(input logic [1:0] size,
                                        input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/openfire_lane_steer.sv
// Combinational big-endian lane steering: byte enables and replicated
// write data from size/offset, and right-justified zero-extended read data.
module openfire_lane_steer
  import openfire_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Decode the lanes for the current access size and byte offset
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_wdata[7:0]}};
        case (i_offset)
          2'd0: begin o_be = BE_B0; o_rdata = {24'h0, i_rdata[31:24]}; end
          2'd1: begin o_be = BE_B1; o_rdata = {24'h0, i_rdata[23:16]}; end
          2'd2: begin o_be = BE_B2; o_rdata = {24'h0, i_rdata[15:8]};  end
          default: begin o_be = BE_B3; o_rdata = {24'h0, i_rdata[7:0]}; end
        endcase
      end
      SZ_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        if (i_offset[1]) begin
          o_be    = BE_H2;
          o_rdata = {16'h0, i_rdata[15:0]};
        end else begin
          o_be    = BE_H0;
          o_rdata = {16'h0, i_rdata[31:16]};
        end
      end
      default: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/openfire_mem_arbiter.sv
// Shares one single-port memory bus between the openfire instruction and
// data ports: data-first arbitration with an imem fairness override,
// big-endian lane steering, misalignment trapping and a bus timeout.
module openfire_mem_arbiter
  import openfire_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FAIR_LIMIT     = 4,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imem_addr,
  input  logic        imem_re,
  output logic [31:0] imem_data,
  output logic        imem_done,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_w,
  input  logic        dmem_we,
  input  logic        dmem_re,
  input  logic [1:0]  dmem_input_sel,
  output logic [31:0] dmem_data_r,
  output logic        dmem_done,
  output logic        dmem_alignment_exception,
  output logic        bus_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int FAIR_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [FAIR_W-1:0] LP_FAIR = FAIR_W'(FAIR_LIMIT);
  localparam logic [CNT_W-1:0] LP_TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic LP_TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] LP_WORD_MASK = 32'hFFFF_FFFC;

  logic [1:0]        r_state;
  logic [FAIR_W-1:0] r_fair;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic              r_mem_we;
  logic              r_mem_req;
  logic [31:0]       r_imem_data;
  logic              r_imem_done;
  logic [31:0]       r_dmem_data_r;
  logic              r_dmem_done;
  logic              r_align_exc;
  logic              r_bus_error;

  logic              w_d_req;
  logic              w_force_i;
  logic              w_grant_d;
  logic              w_d_mis;
  logic              w_timeout;
  logic [1:0]        w_st_size;
  logic [1:0]        w_st_off;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_st_rdata;

  assign w_d_req   = dmem_re | dmem_we;
  assign w_force_i = imem_re & (r_fair == LP_FAIR);
  assign w_grant_d = w_d_req & ~w_force_i;
  assign w_d_mis   = f_misaligned(dmem_input_sel, dmem_addr[1:0]);
  assign w_timeout = LP_TO_EN & (r_cnt == LP_TO_LAST);

  // While idle the steering looks at the live request (to build the bus
  // word); once granted it uses the latched size/offset so a CPU flush
  // cannot disturb read-data extraction.
  assign w_st_size = (r_state == ST_IDLE) ? dmem_input_sel : r_size;
  assign w_st_off  = (r_state == ST_IDLE) ? dmem_addr[1:0] : r_off;

  openfire_lane_steer u_steer (
    .i_size   (w_st_size),
    .i_offset (w_st_off),
    .i_wdata  (dmem_data_w),
    .i_rdata  (mem_rdata),
    .o_be     (w_st_be),
    .o_wdata  (w_st_wdata),
    .o_rdata  (w_st_rdata)
  );

  // Arbitration FSM, bus driver, timeout and completion pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_fair        <= '0;
      r_cnt         <= '0;
      r_size        <= SZ_BYTE;
      r_off         <= 2'b00;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_be      <= 4'h0;
      r_mem_we      <= 1'b0;
      r_mem_req     <= 1'b0;
      r_imem_data   <= 32'h0;
      r_imem_done   <= 1'b0;
      r_dmem_data_r <= 32'h0;
      r_dmem_done   <= 1'b0;
      r_align_exc   <= 1'b0;
      r_bus_error   <= 1'b0;
    end else begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
      r_align_exc <= 1'b0;
      r_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_grant_d) begin
            if (imem_re) r_fair <= r_fair + FAIR_W'(1);
            if (w_d_mis) begin
              r_align_exc <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_mem_addr  <= dmem_addr & LP_WORD_MASK;
              r_mem_wdata <= w_st_wdata;
              r_mem_be    <= w_st_be;
              r_mem_we    <= dmem_we;
              r_mem_req   <= 1'b1;
              r_size      <= dmem_input_sel;
              r_off       <= dmem_addr[1:0];
              r_state     <= ST_DBUS;
            end
          end else if (imem_re) begin
            r_fair      <= '0;
            r_mem_addr  <= imem_addr & LP_WORD_MASK;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= BE_WORD;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_state     <= ST_IBUS;
          end
        end
        ST_IBUS, ST_DBUS: begin
          if (mem_ack || w_timeout) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_DONE;
            if (!mem_ack) r_bus_error <= 1'b1;
            if (r_state == ST_IBUS) begin
              r_imem_done <= 1'b1;
              r_imem_data <= mem_ack ? mem_rdata : 32'h0;
            end else begin
              r_dmem_done   <= 1'b1;
              r_dmem_data_r <= mem_ack ? w_st_rdata : 32'h0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_data                = r_imem_data;
  assign imem_done                = r_imem_done;
  assign dmem_data_r              = r_dmem_data_r;
  assign dmem_done                = r_dmem_done;
  assign dmem_alignment_exception = r_align_exc;
  assign bus_error                = r_bus_error;
  assign mem_addr                 = r_mem_addr;
  assign mem_wdata                = r_mem_wdata;
  assign mem_be                   = r_mem_be;
  assign mem_we                   = r_mem_we;
  assign mem_req                  = r_mem_req;

endmodule
